// File: rtl/sram_fifo_ctrl.sv
// rtl/sram_fifo_ctrl.sv - FIFO controller sequencing a dual-port SRAM with registered read
// Optional sticky overflow/underflow flags: define SRAM_FIFO_ERR_FLAGS_EN.
module sram_fifo_ctrl #(
    parameter int DW = 8,
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    output logic          full,
    input  logic          pop,
    output logic [DW-1:0] pop_data,
    output logic          pop_valid,
    output logic          empty,
    output logic [AW:0]   count,
    output logic [DW-1:0] sram_din,
    output logic          sram_wen,
    output logic [AW-1:0] sram_addrw,
    output logic          sram_ren,
    output logic [AW-1:0] sram_addrr,
    input  logic [DW-1:0] sram_dout,
    output logic          ovf,
    output logic          udf
);

    logic [AW:0] wptr;
    logic [AW:0] rptr;
    logic        push_acc;
    logic        pop_acc;

    // count never exceeds 2**AW, so its top bit alone marks the full state
    assign full  = count[AW];
    assign empty = (count == '0);

    assign push_acc = push & ~full;
    assign pop_acc  = pop & ~empty;

    assign sram_wen   = push_acc;
    assign sram_addrw = wptr[AW-1:0];
    assign sram_din   = push_data;
    assign sram_ren   = pop_acc;
    assign sram_addrr = rptr[AW-1:0];
    assign pop_data   = sram_dout;

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr      <= '0;
            rptr      <= '0;
            count     <= '0;
            pop_valid <= 1'b0;
        end else begin
            pop_valid <= pop_acc;
            if (push_acc) wptr <= wptr + 1'b1;
            if (pop_acc) rptr <= rptr + 1'b1;
            count <= count + {{AW{1'b0}}, push_acc} - {{AW{1'b0}}, pop_acc};
        end
    end

`ifdef SRAM_FIFO_ERR_FLAGS_EN
    logic ovf_q;
    logic udf_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            if (push & full) ovf_q <= 1'b1;
            if (pop & empty) udf_q <= 1'b1;
        end
    end

    assign ovf = ovf_q;
    assign udf = udf_q;
`else
    assign ovf = 1'b0;
    assign udf = 1'b0;
`endif

endmodule
